// File: rtl/multicycle_control_if.sv
// Shared-memory port between the multicycle control unit and the memory.
// Handshake: the master raises mem_req together with iord/mem_we and holds all three
// stable until the slave answers mem_ready=1, which completes the access in that same
// cycle; mem_ready seen while mem_req=0 carries no meaning and is ignored.
interface multicycle_control_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output iord, input mem_ready);
   modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// wait-state timeout, illegal-opcode trap, SYSTEM halt and retired-instruction counter.
module multicycle_control #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.master mem,
   input  logic [6:0]           opcode,
   input  logic                 branch_taken,
   output logic                 ir_write,
   output logic                 mdr_write,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic                 pc_src,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic [1:0]           result_src,
   output logic                 branch,
   output logic                 jal,
   output logic                 jalr,
   output logic                 retire,
   output logic [CNT_W-1:0]     retired,
   output logic                 halted,
   output logic [1:0]           err_code,
   output logic [2:0]           state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALT
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   // Wide enough to hold TIMEOUT itself; one bit when the timeout is disabled.
   localparam int WW = $clog2(TIMEOUT + 2);

   state_t        state, state_n;
   logic [WW-1:0] wait_cnt;
   logic [1:0]    trap_code;
   logic          timeout_hit;
   logic          is_r, is_lw, is_i, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc, is_sys;
   logic          illegal;

   assign is_r     = (opcode == OP_R);
   assign is_lw    = (opcode == OP_LW);
   assign is_i     = (opcode == OP_I);
   assign is_sw    = (opcode == OP_SW);
   assign is_br    = (opcode == OP_BR);
   assign is_jal   = (opcode == OP_JAL);
   assign is_jalr  = (opcode == OP_JALR);
   assign is_lui   = (opcode == OP_LUI);
   assign is_auipc = (opcode == OP_AUIPC);
   assign is_sys   = (opcode == OP_SYS);
   assign illegal  = !(is_r | is_lw | is_i | is_sw | is_br | is_jal | is_jalr |
                       is_lui | is_auipc | is_sys);

   // A ready in the limit cycle still completes the access.
   assign timeout_hit = (TIMEOUT > 0) && !mem.mem_ready && (int'(wait_cnt) == TIMEOUT - 1);
   assign state_dbg   = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_n;
   end

   always_comb begin
      state_n     = state;
      trap_code   = 2'b00;
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      mem.iord    = 1'b0;
      ir_write    = 1'b0;
      mdr_write   = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      pc_src      = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      result_src  = 2'b00;
      branch      = 1'b0;
      jal         = 1'b0;
      jalr        = 1'b0;
      retire      = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem.mem_req = 1'b1;
               if (mem.mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_n  = S_DECODE;
               end else if (timeout_hit) begin
                  trap_code = 2'b10;
                  state_n   = S_TRAP;
               end
            end
            S_DECODE: begin
               if (illegal) begin
                  trap_code = 2'b01;
                  state_n   = S_TRAP;
               end else if (is_sys) begin
                  state_n = S_HALT;
               end else begin
                  state_n = S_EXEC;
               end
            end
            S_EXEC: begin
               state_n = S_WB;
               if (is_r) begin
                  alu_op = 2'b10;
               end else if (is_i) begin
                  alu_src_b = 2'b01;
                  alu_op    = 2'b11;
               end else if (is_lui) begin
                  alu_src_a = 2'b10;
                  alu_src_b = 2'b01;
               end else if (is_auipc) begin
                  alu_src_a = 2'b01;
                  alu_src_b = 2'b01;
               end else if (is_lw || is_sw) begin
                  alu_src_b = 2'b01;
                  state_n   = S_MEM;
               end else if (is_br) begin
                  alu_op   = 2'b01;
                  branch   = 1'b1;
                  pc_write = branch_taken;
                  pc_src   = 1'b1;
                  retire   = 1'b1;
                  state_n  = S_FETCH;
               end else begin
                  alu_src_a  = is_jal ? 2'b01 : 2'b00;
                  alu_src_b  = 2'b01;
                  pc_write   = 1'b1;
                  pc_src     = 1'b1;
                  reg_write  = 1'b1;
                  result_src = 2'b10;
                  jal        = is_jal;
                  jalr       = is_jalr;
                  retire     = 1'b1;
                  state_n    = S_FETCH;
               end
            end
            S_MEM: begin
               mem.mem_req = 1'b1;
               mem.iord    = 1'b1;
               mem.mem_we  = is_sw;
               if (mem.mem_ready) begin
                  if (is_sw) begin
                     retire  = 1'b1;
                     state_n = S_FETCH;
                  end else begin
                     mdr_write = 1'b1;
                     state_n   = S_WB;
                  end
               end else if (timeout_hit) begin
                  trap_code = 2'b10;
                  state_n   = S_TRAP;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               result_src = is_lw ? 2'b01 : 2'b00;
               retire     = 1'b1;
               state_n    = S_FETCH;
            end
            default: state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state_n != state) begin
         wait_cnt <= '0;
      end else if ((state == S_FETCH || state == S_MEM) && !mem.mem_ready &&
                   int'(wait_cnt) < TIMEOUT) begin
         wait_cnt <= wait_cnt + WW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired  <= '0;
         halted   <= 1'b0;
         err_code <= 2'b00;
      end else begin
         if (retire && retired != {CNT_W{1'b1}}) retired <= retired + CNT_W'(1);
         if (state_n == S_HALT) halted <= 1'b1;
         if (state_n == S_TRAP && state != S_TRAP) err_code <= trap_code;
      end
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle RV32I control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding a single-cycle control word. Drives the shared-memory datapath with a req/ready handshake, with a parametrised wait-state timeout. Adds AUIPC and SYSTEM (halt), illegal-opcode trapping, and a retired-instruction counter. Sits between the instruction register and the datapath muxes, register file and memory port.

## Interface
- TIMEOUT, 16: max wait cycles for mem_ready per access; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from the IR; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- branch_taken  in  1  comparator result from the ALU, valid in EXEC.
- mem_req, mem_we, iord  out  1 each  memory request, write enable, address select (0=PC, 1=ALU result).
- ir_write, mdr_write, pc_write, reg_write  out  1 each  register load strobes.
- pc_src  out  1  0=PC+4, 1=ALU target.
- alu_src_a  out  2  00=rs1, 01=old PC, 10=zero.
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4.
- alu_op  out  2  00=add, 01=branch compare, 10=R funct, 11=I funct.
- result_src  out  2  00=ALU, 01=MDR, 10=PC+4 (link).
- branch, jal, jalr  out  1 each  instruction class flags.
- retire  out  1  one-cycle pulse when an instruction completes.
- retired  out  CNT_W  saturating count of retired instructions.
- halted  out  1  sticky, SYSTEM opcode reached.
- err_code  out  2  sticky: 00=none, 01=illegal opcode, 10=bus timeout.

## Operation
- Opcodes: R 0110011, LW 0000011, I-ALU 0010011, SW 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011. Any other opcode is illegal.
- FETCH: mem_req=1, iord=0, mem_we=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0. Next state is DECODE.
- DECODE: no strobes. Illegal opcode -> TRAP (err_code=01). SYSTEM -> HALT. Otherwise -> EXEC.
- EXEC by class:
  - R: a=rs1, b=rs2, alu_op=10 -> WB.
  - I-ALU: a=rs1, b=imm, alu_op=11 -> WB.
  - LUI: a=zero, b=imm, op=00 -> WB.
  - AUIPC: a=old PC, b=imm, op=00 -> WB.
  - LW/SW: a=rs1, b=imm, op=00 -> MEM.
  - BRANCH: op=01, branch=1, pc_write=branch_taken, pc_src=1 -> FETCH, retire.
  - JAL: jal=1, a=old PC, b=imm, pc_write=1, pc_src=1, reg_write=1, result_src=10 -> FETCH, retire.
  - JALR: same as JAL with a=rs1, jalr=1 instead of jal.
- MEM: mem_req=1, iord=1, mem_we=(SW). On mem_ready: SW -> FETCH with retire; LW -> mdr_write=1, then WB.
- WB: reg_write=1, result_src=01 for LW, 00 otherwise -> FETCH, retire.
- TRAP and HALT are absorbing until rst. All strobes are 0 in these states. mem_req=0.
- retired increments on each retire pulse and saturates at all-ones.

## Timing
- Reset (async assert):
  - state=FETCH; wait counter, retired, halted, err_code all clear.
  - While rst is high, all outputs are 0, including mem_req.
  - First mem_req is in the first cycle after rst deasserts.
- Strobes in FETCH and MEM are Mealy on mem_ready. All others are Moore on state and opcode.
- Zero-wait latency (cycles from FETCH entry to retire): BRANCH/JAL/JALR 3; R/I/LUI/AUIPC/SW 4; LW 5. Each wait cycle adds 1.
- Handshake:
  - mem_req, iord and mem_we are held stable until the cycle mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
- Timeout:
  - The wait counter clears on entering FETCH or MEM and increments each cycle without mem_ready.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with no mem_ready, the next state is TRAP with err_code=10.
  - mem_ready in the same cycle the limit is reached wins: the access completes normally.
- Reset mid-access: mem_req drops immediately and no strobe fires.

## Test plan
- Reset, then ADDI (0010011) with mem_ready always 1 -> ir_write at cycle 1, reg_write at cycle 4, retire at cycle 4, retired=1.
- LW with 2 wait cycles in FETCH and 3 in MEM -> retire 10 cycles after reset release. mdr_write fires once, in the MEM ready cycle. result_src=01 in WB.
- BEQ with branch_taken=0, then with branch_taken=1 -> pc_write=0 and pc_write=1 in EXEC respectively. Each retires after 3 cycles.
- Opcode 0000000 -> TRAP after DECODE, err_code=01, no reg_write, retired unchanged. A later rst clears err_code.
- TIMEOUT=4 with mem_ready held 0 in FETCH -> err_code=10 after 4 wait cycles, mem_req=0 afterwards. A second run with mem_ready=1 exactly on the 4th cycle completes normally.
- CNT_W=3 with 9 JALs -> retired saturates at 7. SYSTEM afterwards -> halted=1, mem_req stays 0.
